uart_frame_receiver: RTL and testbench

- Receive side of the FPGA↔PC UART link. Deserialises 8N1 bytes using the shared 16× oversampling enable.
- Hunts for the two-byte header 0x5A 0x5A, then assembles the following 20 payload bytes into a 160-bit word.
- Sits beside the precise clock divider. Takes its divide_clken as clken_16bps and delivers frames to user logic.

---
 rtl/uart_frame_pkg.sv | 25 ++
 rtl/uart_byte_receive.sv | 132 +++++++++++++
 rtl/uart_frame_receiver.sv | 109 ++++++++++
 tb/tb_uart_frame_receiver.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared constants and state encodings for the UART frame receiver.
// Oversampling ratio, sampling point and the two FSM encodings live here.
package uart_frame_pkg;

  localparam logic [7:0]  HDR_BYTE_DEFAULT      = 8'h5A;
  localparam int unsigned PAYLOAD_BYTES_DEFAULT = 20;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);

  typedef enum logic [1:0] {
    BitIdle  = 2'd0,
    BitStart = 2'd1,
    BitData  = 2'd2,
    BitStop  = 2'd3
  } bit_state_e;

  typedef enum logic [1:0] {
    FrmHunt0   = 2'd0,
    FrmHunt1   = 2'd1,
    FrmPayload = 2'd2
  } frame_state_e;

endpackage

// File: rtl/uart_byte_receive.sv
// 8N1 byte deserialiser: input synchroniser, edge detect and bit FSM.
// All counting advances only on the 16x oversampling enable.
module uart_byte_receive
  import uart_frame_pkg::*;
(
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       clken_16bps,
  input  logic       uart_rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);

  // START samples on the 7th tick after the detected edge, then every 16 ticks.
  localparam logic [TICK_W-1:0] START_LAST = TICK_W'(MID_TICK - 1);
  localparam logic [TICK_W-1:0] BIT_LAST   = TICK_W'(OVERSAMPLE - 1);

  logic rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic fall;

  bit_state_e        state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              err_hold_q, err_hold_d;
  logic              byte_valid_q, byte_valid_d;
  logic              byte_err_q, byte_err_d;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      if (clken_16bps) begin
        rxd_prev_q <= rxd_sync_q;
      end
    end
  end

  assign fall = rxd_prev_q & ~rxd_sync_q;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BitIdle;
      tick_q       <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      err_hold_q   <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      err_hold_q   <= err_hold_d;
      byte_valid_q <= byte_valid_d;
      byte_err_q   <= byte_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    err_hold_d   = err_hold_q;
    byte_valid_d = 1'b0;
    byte_err_d   = 1'b0;
    if (clken_16bps) begin
      unique case (state_q)
        BitIdle: begin
          if (fall) begin
            state_d = BitStart;
            tick_d  = '0;
          end
        end
        BitStart: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == START_LAST) begin
            tick_d = '0;
            if (!rxd_sync_q) begin
              state_d   = BitData;
              bit_idx_d = '0;
            end else begin
              state_d = BitIdle;
            end
          end
        end
        BitData: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == BIT_LAST) begin
            shift_d   = {rxd_sync_q, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_d = BitStop;
            end
          end
        end
        BitStop: begin
          tick_d = tick_q + 1'b1;
          // After a framing error, wait for a high line so a held-low break
          // cannot be mistaken for a new start bit.
          if (err_hold_q) begin
            if (rxd_sync_q) begin
              state_d    = BitIdle;
              err_hold_d = 1'b0;
            end
          end else if (tick_q == BIT_LAST) begin
            if (rxd_sync_q) begin
              byte_valid_d = 1'b1;
              state_d      = BitIdle;
            end else begin
              byte_err_d = 1'b1;
              err_hold_d = 1'b1;
            end
          end
        end
        default: state_d = BitIdle;
      endcase
    end
  end

  assign byte_data  = shift_q;
  assign byte_valid = byte_valid_q;
  assign byte_err   = byte_err_q;

endmodule

// File: rtl/uart_frame_receiver.sv
// UART frame receiver: hunts for a two-byte header, then assembles a fixed
// number of payload bytes into one wide word delivered with a valid pulse.
module uart_frame_receiver
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  HDR_BYTE      = HDR_BYTE_DEFAULT,
  parameter int unsigned PAYLOAD_BYTES = PAYLOAD_BYTES_DEFAULT
) (
  input  logic                       clk_50m,
  input  logic                       rst_n,
  input  logic                       clken_16bps,
  input  logic                       uart_rxd,
  output logic [8*PAYLOAD_BYTES-1:0] frame_data,
  output logic                       frame_valid,
  output logic                       byte_err,
  output logic                       frame_abort
);

  localparam int unsigned FRAME_W = 8 * PAYLOAD_BYTES;
  localparam int unsigned CNT_W   = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_BYTES - 1);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  frame_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] frame_data_q, frame_data_d;
  logic               frame_valid_q, frame_valid_d;
  logic               frame_abort_q, frame_abort_d;

  uart_byte_receive u_byte (
    .clk_50m     (clk_50m),
    .rst_n       (rst_n),
    .clken_16bps (clken_16bps),
    .uart_rxd    (uart_rxd),
    .byte_data   (rx_byte),
    .byte_valid  (rx_valid),
    .byte_err    (rx_err)
  );

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FrmHunt0;
      cnt_q         <= '0;
      shift_q       <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    frame_abort_d = 1'b0;
    if (rx_err) begin
      // Partial payload is dropped; frame_data keeps the last good frame.
      if (state_q == FrmPayload) begin
        frame_abort_d = 1'b1;
      end
      state_d = FrmHunt0;
    end else if (rx_valid) begin
      unique case (state_q)
        FrmHunt0: begin
          if (rx_byte == HDR_BYTE) begin
            state_d = FrmHunt1;
          end
        end
        FrmHunt1: begin
          if (rx_byte == HDR_BYTE) begin
            state_d = FrmPayload;
            cnt_d   = '0;
          end else begin
            state_d = FrmHunt0;
          end
        end
        FrmPayload: begin
          shift_d = {shift_q[FRAME_W-9:0], rx_byte};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            frame_data_d  = shift_d;
            frame_valid_d = 1'b1;
            state_d       = FrmHunt0;
          end
        end
        default: state_d = FrmHunt0;
      endcase
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_abort = frame_abort_q;
  assign byte_err    = rx_err;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Directed bench for uart_frame_receiver: serial frames, header hunting,
// framing errors, idle glitches and mid-frame reset.
module tb_uart_frame_receiver;

  localparam int TickDiv = 2;
  localparam int BitClks = 16 * TickDiv;

  localparam logic [159:0] ExpCount = 160'h000102030405060708090a0b0c0d0e0f10111213;
  localparam logic [159:0] ExpA5    = {20{8'hA5}};
  localparam logic [159:0] Exp5A    = {20{8'h5A}};
  localparam logic [159:0] Exp3C    = {20{8'h3C}};
  localparam logic [159:0] ExpC0    = 160'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecfd0d1d2d3;

  logic         clk_50m = 1'b0;
  logic         rst_n = 1'b0;
  logic         clken_16bps = 1'b0;
  logic         uart_rxd = 1'b1;
  logic [159:0] frame_data;
  logic         frame_valid;
  logic         byte_err;
  logic         frame_abort;

  int total = 0;
  int bad = 0;
  int div_cnt = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  int abort_cnt = 0;
  int bv_cnt = 0;
  int lat_bad = 0;
  logic prev_bv = 1'b0;

  uart_frame_receiver dut (
    .clk_50m     (clk_50m),
    .rst_n       (rst_n),
    .clken_16bps (clken_16bps),
    .uart_rxd    (uart_rxd),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .byte_err    (byte_err),
    .frame_abort (frame_abort)
  );

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) begin
    div_cnt     <= (div_cnt == TickDiv - 1) ? 0 : div_cnt + 1;
    clken_16bps <= (div_cnt == TickDiv - 1);
  end

  // Pulse counters; frame_valid must follow the final byte_valid by one cycle.
  always @(negedge clk_50m) begin
    if (frame_valid) begin
      fv_cnt <= fv_cnt + 1;
      if (!prev_bv) lat_bad <= lat_bad + 1;
    end
    if (byte_err) err_cnt <= err_cnt + 1;
    if (frame_abort) abort_cnt <= abort_cnt + 1;
    if (dut.rx_valid) bv_cnt <= bv_cnt + 1;
    prev_bv <= dut.rx_valid;
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int extra_low);
    uart_rxd = 1'b0;
    wait_clks(BitClks);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_clks(BitClks);
    end
    uart_rxd = stop_bit;
    wait_clks(BitClks + extra_low);
    uart_rxd = 1'b1;
    wait_clks(4 * TickDiv);
  endtask

  task automatic send_hdr();
    send_byte(8'h5A, 1'b1, 0);
    send_byte(8'h5A, 1'b1, 0);
  endtask

  initial begin
    int fv0, err0, ab0, bv0;

    wait_clks(5);
    check("rst frame_data", frame_data, '0);
    check("rst frame_valid", {159'd0, frame_valid}, '0);
    check("rst byte_err", {159'd0, byte_err}, '0);
    check("rst frame_abort", {159'd0, frame_abort}, '0);
    rst_n = 1'b1;
    wait_clks(8 * TickDiv);

    // Counting payload
    fv0 = fv_cnt; err0 = err_cnt; ab0 = abort_cnt;
    send_hdr();
    for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b1, 0);
    wait_clks(4);
    check("t1 frames", fv_cnt - fv0, 1);
    check("t1 data", frame_data, ExpCount);
    check("t1 errs", err_cnt - err0, 0);
    check("t1 aborts", abort_cnt - ab0, 0);

    // Broken headers before a good one
    fv0 = fv_cnt; err0 = err_cnt;
    send_byte(8'h12, 1'b1, 0);
    send_byte(8'h5A, 1'b1, 0);
    send_byte(8'h34, 1'b1, 0);
    send_byte(8'h5A, 1'b1, 0);
    send_byte(8'h5A, 1'b1, 0);
    for (int i = 0; i < 20; i++) send_byte(8'hA5, 1'b1, 0);
    wait_clks(4);
    check("t2 frames", fv_cnt - fv0, 1);
    check("t2 data", frame_data, ExpA5);
    check("t2 errs", err_cnt - err0, 0);

    // Header bytes as payload data
    fv0 = fv_cnt;
    send_hdr();
    for (int i = 0; i < 20; i++) send_byte(8'h5A, 1'b1, 0);
    wait_clks(4);
    check("t3 frames", fv_cnt - fv0, 1);
    check("t3 data", frame_data, Exp5A);
    fv0 = fv_cnt;
    send_byte(8'h5A, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    wait_clks(4);
    check("t3 lone 5A frames", fv_cnt - fv0, 0);
    check("t3 data held", frame_data, Exp5A);

    // Framing error on payload byte 8 with the line held low afterwards
    fv0 = fv_cnt; err0 = err_cnt; ab0 = abort_cnt;
    send_hdr();
    for (int i = 0; i < 7; i++) send_byte(8'h11 + 8'(i), 1'b1, 0);
    send_byte(8'h18, 1'b0, 3 * BitClks);
    wait_clks(4);
    check("t4 errs", err_cnt - err0, 1);
    check("t4 aborts", abort_cnt - ab0, 1);
    check("t4 frames", fv_cnt - fv0, 0);
    check("t4 data kept", frame_data, Exp5A);
    fv0 = fv_cnt; err0 = err_cnt;
    send_hdr();
    for (int i = 0; i < 20; i++) send_byte(8'h3C, 1'b1, 0);
    wait_clks(4);
    check("t4 recover frames", fv_cnt - fv0, 1);
    check("t4 recover data", frame_data, Exp3C);
    check("t4 recover errs", err_cnt - err0, 0);

    // Short low glitch while idle
    bv0 = bv_cnt; err0 = err_cnt;
    uart_rxd = 1'b0;
    wait_clks(3 * TickDiv);
    uart_rxd = 1'b1;
    wait_clks(2 * BitClks);
    check("t5 glitch bytes", bv_cnt - bv0, 0);
    check("t5 glitch errs", err_cnt - err0, 0);

    // Reset during payload byte 10
    send_hdr();
    for (int i = 0; i < 9; i++) send_byte(8'h70 + 8'(i), 1'b1, 0);
    uart_rxd = 1'b0;
    wait_clks(BitClks);
    uart_rxd = 1'b1;
    wait_clks(2 * BitClks);
    check("t6 data before rst", frame_data, Exp3C);
    rst_n = 1'b0;
    wait_clks(2);
    check("t6 rst frame_data", frame_data, '0);
    check("t6 rst frame_valid", {159'd0, frame_valid}, '0);
    check("t6 rst byte_err", {159'd0, byte_err}, '0);
    check("t6 rst frame_abort", {159'd0, frame_abort}, '0);
    wait_clks(BitClks);
    rst_n = 1'b1;
    wait_clks(8 * TickDiv);
    fv0 = fv_cnt;
    send_hdr();
    for (int i = 0; i < 20; i++) send_byte(8'hC0 + 8'(i), 1'b1, 0);
    wait_clks(4);
    check("t6 frames", fv_cnt - fv0, 1);
    check("t6 data", frame_data, ExpC0);

    check("valid latency", lat_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
